// File: rtl/ddr_line_arbiter.sv
// Round-robin bridge from NUM_CH word-granular requesters to a DDR3 line-wide user port.
// One transaction in flight: grant, line command, optional write beat, read wait, response.
module ddr_line_arbiter #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned ADDR_W     = 29,
  parameter int unsigned LINE_W     = 256,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned RD_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     calib_done,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH-1:0]        req_we,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*WORD_W-1:0] req_wdata,
  input  logic [NUM_CH*WORD_W/8-1:0] req_be,
  output logic [NUM_CH-1:0]        rsp_valid,
  output logic                     rsp_err,
  output logic [WORD_W-1:0]        rsp_rdata,
  input  logic                     cmd_ready,
  output logic                     cmd_en,
  output logic [2:0]               cmd,
  output logic [ADDR_W-1:0]        addr,
  input  logic                     wr_data_rdy,
  output logic                     wr_data_en,
  output logic                     wr_data_end,
  output logic [LINE_W-1:0]        wr_data,
  output logic [LINE_W/8-1:0]      wr_data_mask,
  input  logic [LINE_W-1:0]        rd_data,
  input  logic                     rd_data_valid
);

  localparam int unsigned WPL   = LINE_W / WORD_W;
  localparam int unsigned SEL_W = $clog2(WPL);
  localparam int unsigned BE_W  = WORD_W / 8;
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [2:0]  CMD_RD = 3'b001;
  localparam logic [2:0]  CMD_WR = 3'b000;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WDATA, S_RWAIT, S_RESP} state_t;

  state_t              r_state;
  logic [CH_W-1:0]     r_rr;
  logic [CH_W-1:0]     r_gnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [WORD_W-1:0]   r_wdata;
  logic [BE_W-1:0]     r_be;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_any;
  logic [CH_W-1:0]     w_idx;
  logic [CH_W-1:0]     w_gnt_idx;
  logic [NUM_CH-1:0]   w_grant_oh;
  logic                w_accept;
  logic [ADDR_W-1:0]   w_req_addr;
  logic [NUM_CH-1:0]   w_own_oh;
  logic [SEL_W-1:0]    w_sel;
  logic [LINE_W/8-1:0] w_mask;
  logic [WORD_W-1:0]   w_rd_word;

  // First valid channel at or after the round-robin pointer
  always_comb begin
    w_any     = 1'b0;
    w_idx     = '0;
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = CH_W'((32'(r_rr) + 32'(k)) % NUM_CH);
      if (!w_any && req_valid[w_idx]) begin
        w_any     = 1'b1;
        w_gnt_idx = w_idx;
      end
    end
  end

  assign w_grant_oh = w_any ? (NUM_CH'(1) << w_gnt_idx) : '0;
  assign w_accept   = (r_state == S_IDLE) && calib_done && w_any;
  assign req_ready  = (rst_n && calib_done && (r_state == S_IDLE)) ? w_grant_oh : '0;
  assign w_req_addr = req_addr[32'(w_gnt_idx) * ADDR_W +: ADDR_W];
  assign w_own_oh   = NUM_CH'(1) << r_gnt;
  assign w_sel      = r_addr[SEL_W-1:0];
  assign w_rd_word  = rd_data[32'(w_sel) * WORD_W +: WORD_W];

  // Only the addressed word's byte lanes are writable; the rest of the line is masked
  always_comb begin
    w_mask = '1;
    for (int w = 0; w < WPL; w++) begin
      if (SEL_W'(w) == w_sel) w_mask[w*BE_W +: BE_W] = ~r_be;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_rr         <= '0;
      r_gnt        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_cnt        <= '0;
      rsp_valid    <= '0;
      rsp_err      <= 1'b0;
      rsp_rdata    <= '0;
      cmd_en       <= 1'b0;
      cmd          <= 3'b000;
      addr         <= '0;
      wr_data_en   <= 1'b0;
      wr_data_end  <= 1'b0;
      wr_data      <= '0;
      wr_data_mask <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_gnt   <= w_gnt_idx;
            r_rr    <= CH_W'((32'(w_gnt_idx) + 32'd1) % NUM_CH);
            r_we    <= req_we[w_gnt_idx];
            r_addr  <= w_req_addr;
            r_wdata <= req_wdata[32'(w_gnt_idx) * WORD_W +: WORD_W];
            r_be    <= req_be[32'(w_gnt_idx) * BE_W +: BE_W];
            cmd_en  <= 1'b1;
            cmd     <= req_we[w_gnt_idx] ? CMD_WR : CMD_RD;
            addr    <= {w_req_addr[ADDR_W-1:SEL_W], SEL_W'(0)};
            r_state <= S_CMD;
          end
        end
        S_CMD: begin
          if (cmd_ready) begin
            cmd_en <= 1'b0;
            cmd    <= 3'b000;
            addr   <= '0;
            r_cnt  <= '0;
            if (r_we) begin
              wr_data_en   <= 1'b1;
              wr_data_end  <= 1'b1;
              wr_data      <= {WPL{r_wdata}};
              wr_data_mask <= w_mask;
              r_state      <= S_WDATA;
            end else begin
              r_state <= S_RWAIT;
            end
          end
        end
        S_WDATA: begin
          if (wr_data_rdy) begin
            wr_data_en   <= 1'b0;
            wr_data_end  <= 1'b0;
            wr_data      <= '0;
            wr_data_mask <= '0;
            rsp_valid    <= w_own_oh;
            rsp_err      <= 1'b0;
            rsp_rdata    <= '0;
            r_state      <= S_RESP;
          end
        end
        S_RWAIT: begin
          // Expiry fires as the count advances to RD_TIMEOUT-1; data in that cycle wins
          r_cnt <= r_cnt + CNT_W'(1);
          if (rd_data_valid) begin
            rsp_valid <= w_own_oh;
            rsp_err   <= 1'b0;
            rsp_rdata <= w_rd_word;
            r_state   <= S_RESP;
          end else if (r_cnt == CNT_W'(RD_TIMEOUT - 2)) begin
            rsp_valid <= w_own_oh;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            r_state   <= S_RESP;
          end
        end
        S_RESP: begin
          rsp_valid <= '0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_line_arbiter.sv
// Scenario bench for ddr_line_arbiter: reset/calibration, read extraction, byte write,
// round-robin order, backpressure hold and read timeout, with a response scoreboard.
module tb_ddr_line_arbiter;

  localparam int NUM_CH = 2;
  localparam int ADDR_W = 29;
  localparam int LINE_W = 256;
  localparam int WORD_W = 32;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic                     calib_done = 1'b0;
  logic [NUM_CH-1:0]        req_valid = '0;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH-1:0]        req_we = '0;
  logic [NUM_CH*ADDR_W-1:0] req_addr = '0;
  logic [NUM_CH*WORD_W-1:0] req_wdata = '0;
  logic [NUM_CH*4-1:0]      req_be = '0;
  logic [NUM_CH-1:0]        rsp_valid;
  logic                     rsp_err;
  logic [WORD_W-1:0]        rsp_rdata;
  logic                     cmd_ready = 1'b0;
  logic                     cmd_en;
  logic [2:0]               cmd;
  logic [ADDR_W-1:0]        addr;
  logic                     wr_data_rdy = 1'b0;
  logic                     wr_data_en;
  logic                     wr_data_end;
  logic [LINE_W-1:0]        wr_data;
  logic [LINE_W/8-1:0]      wr_data_mask;
  logic [LINE_W-1:0]        rd_data = '0;
  logic                     rd_data_valid = 1'b0;

  typedef struct {
    int          ch;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  ddr_line_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .WORD_W(WORD_W), .RD_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .calib_done(calib_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .cmd_ready(cmd_ready), .cmd_en(cmd_en), .cmd(cmd), .addr(addr),
    .wr_data_rdy(wr_data_rdy), .wr_data_en(wr_data_en), .wr_data_end(wr_data_end),
    .wr_data(wr_data), .wr_data_mask(wr_data_mask),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  function automatic logic [31:0] line_word(input int i);
    return 32'hBEEF_0000 + 32'(i);
  endfunction

  function automatic logic [LINE_W-1:0] mk_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = line_word(i);
    return l;
  endfunction

  task automatic set_req(input int ch, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    req_we[ch]              = we;
    req_addr[ch*ADDR_W +: ADDR_W] = a;
    req_wdata[ch*32 +: 32]  = d;
    req_be[ch*4 +: 4]       = be;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) tick();
    settle();
    n_checks++;
    if (req_ready !== 2'b00) begin
      n_fail++; $display("FAIL reset_req_ready: got %b expected 00", req_ready);
    end
    n_checks++;
    if ({cmd_en, cmd, addr} !== '0) begin
      n_fail++; $display("FAIL reset_cmd: got en=%b cmd=%b addr=%h expected all 0", cmd_en, cmd, addr);
    end
    n_checks++;
    if ({wr_data_en, wr_data_end, wr_data, wr_data_mask} !== '0) begin
      n_fail++; $display("FAIL reset_wdata: got en=%b end=%b mask=%h expected all 0", wr_data_en, wr_data_end, wr_data_mask);
    end
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_rsp: got v=%b e=%b d=%h expected all 0", rsp_valid, rsp_err, rsp_rdata);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_calib();
    calib_done = 1'b0;
    set_req(0, 1'b0, 29'h10, 32'h0, 4'h0);
    req_valid = 2'b01;
    for (int i = 0; i < 20; i++) begin
      tick();
      settle();
      n_checks++;
      if (req_ready !== 2'b00 || cmd_en !== 1'b0) begin
        n_fail++; $display("FAIL calib_hold: cycle %0d got ready=%b cmd_en=%b expected 00/0", i, req_ready, cmd_en);
      end
    end
    tick();
    calib_done = 1'b1;
    settle();
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL calib_grant: got %b expected 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    settle();
    n_checks++;
    if ({cmd_en, cmd, addr} !== {1'b1, 3'b001, 29'h10}) begin
      n_fail++; $display("FAIL calib_cmd: got en=%b cmd=%b addr=%h expected 1/001/10", cmd_en, cmd, addr);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata, cmd_en, cmd, addr,
         wr_data_en, wr_data_end, wr_data, wr_data_mask} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got cmd_en=%b cmd=%b addr=%h ready=%b expected all 0", cmd_en, cmd, addr, req_ready);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      settle();
      n_checks++;
      if (rsp_valid !== 2'b00 || cmd_en !== 1'b0) begin
        n_fail++; $display("FAIL midreset_abandon: got rsp_valid=%b cmd_en=%b expected 00/0", rsp_valid, cmd_en);
      end
    end
  endtask

  task automatic test_read_extract();
    exp_t e;
    logic [LINE_W-1:0] l;
    l = mk_line();
    l[5*32 +: 32] = 32'hCAFEBABE;
    rd_data = l;
    set_req(1, 1'b0, 29'h0D, 32'h0, 4'h0);
    tick();
    req_valid = 2'b10;
    settle();
    n_checks++;
    if (req_ready !== 2'b10) begin
      n_fail++; $display("FAIL rd_grant: got %b expected 10", req_ready);
    end
    e.ch = 1; e.rdata = 32'hCAFEBABE; e.err = 1'b0;
    sb.push_back(e);
    tick();
    req_valid = 2'b00;
    cmd_ready = 1'b1;
    settle();
    n_checks++;
    if ({cmd_en, cmd, addr} !== {1'b1, 3'b001, 29'h08}) begin
      n_fail++; $display("FAIL rd_cmd: got en=%b cmd=%b addr=%h expected 1/001/08", cmd_en, cmd, addr);
    end
    tick();
    cmd_ready = 1'b0;
    rd_data_valid = 1'b1;
    settle();
    n_checks++;
    if (rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL rd_early_rsp: got %b expected 00", rsp_valid);
    end
    tick();
    rd_data_valid = 1'b0;
    settle();
    if (sb.size() == 0) begin
      n_checks++; n_fail++; $display("FAIL rd_rsp: scoreboard empty");
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (rsp_valid !== (2'b01 << e.ch) || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        n_fail++; $display("FAIL rd_rsp: got v=%b d=%h e=%b expected v=%b d=%h e=%b", rsp_valid, rsp_rdata, rsp_err, 2'b01 << e.ch, e.rdata, e.err);
      end
    end
    tick();
    settle();
    n_checks++;
    if (rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL rd_rsp_width: got %b expected 00", rsp_valid);
    end
  endtask

  task automatic test_byte_write();
    exp_t e;
    set_req(0, 1'b1, 29'h3, 32'h11223344, 4'b0101);
    cmd_ready = 1'b1;
    wr_data_rdy = 1'b1;
    tick();
    req_valid = 2'b01;
    settle();
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL wr_grant: got %b expected 01", req_ready);
    end
    e.ch = 0; e.rdata = 32'h0; e.err = 1'b0;
    sb.push_back(e);
    tick();
    req_valid = 2'b00;
    settle();
    n_checks++;
    if ({cmd_en, cmd, addr} !== {1'b1, 3'b000, 29'h0}) begin
      n_fail++; $display("FAIL wr_cmd: got en=%b cmd=%b addr=%h expected 1/000/0", cmd_en, cmd, addr);
    end
    tick();
    settle();
    n_checks++;
    if ({wr_data_en, wr_data_end} !== 2'b11 || wr_data !== {8{32'h11223344}} ||
        wr_data_mask !== 32'hFFFF_AFFF) begin
      n_fail++; $display("FAIL wr_beat: got en=%b end=%b mask=%h data=%h expected 11 mask=ffffafff", wr_data_en, wr_data_end, wr_data_mask, wr_data);
    end
    tick();
    settle();
    if (sb.size() == 0) begin
      n_checks++; n_fail++; $display("FAIL wr_rsp: scoreboard empty");
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (rsp_valid !== (2'b01 << e.ch) || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        n_fail++; $display("FAIL wr_rsp: got v=%b d=%h e=%b expected v=%b d=%h e=%b", rsp_valid, rsp_rdata, rsp_err, 2'b01 << e.ch, e.rdata, e.err);
      end
    end
    tick();
    cmd_ready = 1'b0;
    wr_data_rdy = 1'b0;
    settle();
    n_checks++;
    if (rsp_valid !== 2'b00 || wr_data_en !== 1'b0) begin
      n_fail++; $display("FAIL wr_after: got rsp_valid=%b wr_data_en=%b expected 00/0", rsp_valid, wr_data_en);
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    int grants = 0;
    int rsps = 0;
    int last = -1;
    int cyc = 0;
    int ch;
    set_req(0, 1'b0, 29'h21, 32'h0, 4'h0);
    set_req(1, 1'b0, 29'h46, 32'h0, 4'h0);
    rd_data = mk_line();
    cmd_ready = 1'b1;
    rd_data_valid = 1'b1;
    tick();
    req_valid = 2'b11;
    while ((grants < 6 || rsps < 6) && cyc < 100) begin
      settle();
      if (req_ready !== 2'b00) begin
        ch = grants % 2;
        n_checks++;
        if (req_ready !== (2'b01 << ch)) begin
          n_fail++; $display("FAIL rr_order: grant %0d got %b expected %b", grants, req_ready, 2'b01 << ch);
        end
        n_checks++;
        if (last >= 0 && req_ready === (2'b01 << last)) begin
          n_fail++; $display("FAIL rr_repeat: grant %0d got %b again", grants, req_ready);
        end
        last = req_ready[1] ? 1 : 0;
        e.ch = ch; e.rdata = line_word(ch == 0 ? 1 : 6); e.err = 1'b0;
        sb.push_back(e);
        grants++;
      end
      if (rsp_valid !== 2'b00) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL rr_rsp: unexpected rsp_valid=%b", rsp_valid);
        end else begin
          e = sb.pop_front();
          n_checks++;
          if (rsp_valid !== (2'b01 << e.ch) || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
            n_fail++; $display("FAIL rr_rsp: got v=%b d=%h e=%b expected v=%b d=%h e=%b", rsp_valid, rsp_rdata, rsp_err, 2'b01 << e.ch, e.rdata, e.err);
          end
        end
        rsps++;
      end
      tick();
      cyc++;
      if (grants >= 6) req_valid = 2'b00;
    end
    n_checks++;
    if (grants != 6 || rsps != 6) begin
      n_fail++; $display("FAIL rr_count: got %0d grants %0d responses expected 6/6", grants, rsps);
    end
    req_valid = 2'b00;
    cmd_ready = 1'b0;
    rd_data_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    exp_t e;
    int hs_cmd = 0;
    int hs_wr = 0;
    set_req(1, 1'b1, 29'h55, 32'hDEADBEEF, 4'b1100);
    cmd_ready = 1'b0;
    wr_data_rdy = 1'b0;
    tick();
    req_valid = 2'b10;
    settle();
    n_checks++;
    if (req_ready !== 2'b10) begin
      n_fail++; $display("FAIL bp_grant: got %b expected 10", req_ready);
    end
    e.ch = 1; e.rdata = 32'h0; e.err = 1'b0;
    sb.push_back(e);
    for (int c = 0; c < 14; c++) begin
      tick();
      req_valid = 2'b00;
      cmd_ready = (c == 7);
      wr_data_rdy = (c == 12);
      settle();
      if (cmd_en && cmd_ready) hs_cmd++;
      if (wr_data_en && wr_data_rdy) hs_wr++;
      if (c <= 7) begin
        n_checks++;
        if ({cmd_en, cmd, addr} !== {1'b1, 3'b000, 29'h50}) begin
          n_fail++; $display("FAIL bp_cmd: cycle %0d got en=%b cmd=%b addr=%h expected 1/000/50", c, cmd_en, cmd, addr);
        end
      end else if (c <= 12) begin
        n_checks++;
        if ({wr_data_en, wr_data_end} !== 2'b11 || wr_data !== {8{32'hDEADBEEF}} ||
            wr_data_mask !== 32'hFF3F_FFFF) begin
          n_fail++; $display("FAIL bp_wdata: cycle %0d got en=%b end=%b mask=%h expected 11 mask=ff3fffff", c, wr_data_en, wr_data_end, wr_data_mask);
        end
      end else begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL bp_rsp: scoreboard empty");
        end else begin
          e = sb.pop_front();
          n_checks++;
          if (rsp_valid !== (2'b01 << e.ch) || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
            n_fail++; $display("FAIL bp_rsp: got v=%b d=%h e=%b expected v=%b d=%h e=%b", rsp_valid, rsp_rdata, rsp_err, 2'b01 << e.ch, e.rdata, e.err);
          end
        end
      end
    end
    n_checks++;
    if (hs_cmd != 1 || hs_wr != 1) begin
      n_fail++; $display("FAIL bp_handshakes: got cmd=%0d wr=%0d expected 1/1", hs_cmd, hs_wr);
    end
    tick();
    cmd_ready = 1'b0;
    wr_data_rdy = 1'b0;
  endtask

  task automatic test_timeout();
    exp_t e;
    int n = 0;
    logic got = 1'b0;
    set_req(0, 1'b0, 29'h07, 32'h0, 4'h0);
    cmd_ready = 1'b1;
    rd_data_valid = 1'b0;
    tick();
    req_valid = 2'b01;
    settle();
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL to_grant: got %b expected 01", req_ready);
    end
    e.ch = 0; e.rdata = 32'h0; e.err = 1'b1;
    sb.push_back(e);
    tick();
    req_valid = 2'b00;
    settle();
    n_checks++;
    if (cmd_en !== 1'b1 || cmd !== 3'b001) begin
      n_fail++; $display("FAIL to_cmd: got en=%b cmd=%b expected 1/001", cmd_en, cmd);
    end
    while (!got && n < 40) begin
      tick();
      settle();
      n++;
      if (rsp_valid !== 2'b00) got = 1'b1;
    end
    n_checks++;
    if (!got || n != 16) begin
      n_fail++; $display("FAIL to_latency: got rsp after %0d cycles (seen=%b) expected 16", n, got);
    end
    if (got) begin
      e = sb.pop_front();
      n_checks++;
      if (rsp_valid !== (2'b01 << e.ch) || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        n_fail++; $display("FAIL to_rsp: got v=%b d=%h e=%b expected v=%b d=%h e=%b", rsp_valid, rsp_rdata, rsp_err, 2'b01 << e.ch, e.rdata, e.err);
      end
    end else begin
      void'(sb.pop_front());
    end
    cmd_ready = 1'b0;
    rd_data = mk_line();
    for (int i = 0; i < 2; i++) begin
      tick();
      rd_data_valid = 1'b1;
      settle();
      n_checks++;
      if (rsp_valid !== 2'b00 || cmd_en !== 1'b0) begin
        n_fail++; $display("FAIL to_stray: got rsp_valid=%b cmd_en=%b expected 00/0", rsp_valid, cmd_en);
      end
    end
    set_req(1, 1'b0, 29'h4A, 32'h0, 4'h0);
    cmd_ready = 1'b1;
    tick();
    req_valid = 2'b10;
    settle();
    n_checks++;
    if (req_ready !== 2'b10) begin
      n_fail++; $display("FAIL to_next_grant: got %b expected 10", req_ready);
    end
    e.ch = 1; e.rdata = line_word(2); e.err = 1'b0;
    sb.push_back(e);
    tick();
    req_valid = 2'b00;
    got = 1'b0;
    n = 1;
    settle();
    while (!got && n < 10) begin
      tick();
      settle();
      n++;
      if (rsp_valid !== 2'b00) got = 1'b1;
    end
    n_checks++;
    if (!got || n != 3) begin
      n_fail++; $display("FAIL to_next_latency: got rsp at cycle %0d (seen=%b) expected 3", n, got);
    end
    if (got) begin
      e = sb.pop_front();
      n_checks++;
      if (rsp_valid !== (2'b01 << e.ch) || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        n_fail++; $display("FAIL to_next_rsp: got v=%b d=%h e=%b expected v=%b d=%h e=%b", rsp_valid, rsp_rdata, rsp_err, 2'b01 << e.ch, e.rdata, e.err);
      end
    end else begin
      void'(sb.pop_front());
    end
    tick();
    cmd_ready = 1'b0;
    rd_data_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_calib();
    test_byte_write();
    test_read_extract();
    test_round_robin();
    test_backpressure();
    test_timeout();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d pending responses expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
